mem_access_initiator: RTL

- Initiator side of the data-memory interface: accepts load/store requests from the CPU datapath over a valid/ready handshake and drives the 64-bit word RAM's address, read/write enables and write data.
- Converts byte addresses to word indices and checks alignment and range. Waits a configurable read latency, captures read data, and returns a held response to the requester.
- Sits between the LEGv8 execute/memory stage and the data RAM.

---
 rtl/mem_access_initiator.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_initiator.sv
// Data-memory initiator: takes CPU load/store requests over valid/ready, drives
// the word-addressed RAM, and returns a held response with alignment/range errors.
module mem_access_initiator #(
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [63:0] mem_data_in,
  input  logic [63:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);
  localparam logic [3:0]  LAST_CNT = 4'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] mem_address_q, mem_address_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic        mem_write_en_q, mem_write_en_d;
  logic [63:0] mem_data_in_q, mem_data_in_d;
  logic        write_q, write_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] req_index;
  logic        req_bad;

  // Full-width range compare so huge byte addresses never alias into the RAM.
  assign req_index = {3'b000, req_addr[63:3]};
  assign req_bad   = (req_addr[2:0] != 3'b000) || (req_index >= DEPTH_W);

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    mem_address_d  = mem_address_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    mem_data_in_d  = mem_data_in_q;
    write_d        = write_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          req_ready_d = 1'b0;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else begin
            state_d       = ISSUE;
            cnt_d         = 4'd0;
            mem_address_d = req_index;
            if (req_write) begin
              mem_write_en_d = 1'b1;
              mem_data_in_d  = req_wdata;
            end else begin
              mem_read_en_d = 1'b1;
            end
          end
        end
      end

      ISSUE: begin
        if (write_q) begin
          mem_write_en_d = 1'b0;
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b0;
          resp_rdata_d   = 64'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Read data is sampled on the edge closing the last read_en cycle.
          if (cnt_q == LAST_CNT) begin
            mem_read_en_d = 1'b0;
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_err_d    = 1'b0;
            resp_rdata_d  = mem_out;
          end
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d        = IDLE;
        req_ready_d    = 1'b1;
        resp_valid_d   = 1'b0;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 64'd0;
      resp_err_q     <= 1'b0;
      mem_address_q  <= 64'd0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_data_in_q  <= 64'd0;
      write_q        <= 1'b0;
      cnt_q          <= 4'd0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      mem_address_q  <= mem_address_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_data_in_q  <= mem_data_in_d;
      write_q        <= write_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_address  = mem_address_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_data_in  = mem_data_in_q;

endmodule
